// File: rtl/cic_decimator.sv
// N-stage CIC decimator with a runtime power-of-two ratio and a valid/ready output register.
// Optional feature macro CIC_ROUND_EN: round half up before the output shift, saturate positive overflow.
module cic_decimator #(
  parameter int STAGES    = 3,
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 8,
  parameter int MAX_DLOG2 = 5,
  localparam int REG_WIDTH = IN_WIDTH + STAGES * MAX_DLOG2,
  localparam int DLW       = $clog2(MAX_DLOG2 + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [DLW-1:0]       dlog2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 overrun
);

  localparam int WW = REG_WIDTH + 1;

  typedef logic [REG_WIDTH-1:0] reg_t;
  typedef logic signed [WW-1:0] wide_t;

`ifdef CIC_ROUND_EN
  localparam wide_t OUT_MAX = {{(WW - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
`endif

  reg_t                 integ      [STAGES];
  reg_t                 integ_next [STAGES];
  reg_t                 dly        [STAGES];
  reg_t                 comb_tap   [STAGES];
  reg_t                 comb_out;
  logic [DLW-1:0]       ratio;
  logic [MAX_DLOG2-1:0] phase;
  logic [MAX_DLOG2-1:0] last_phase;
  logic                 decimate;
  logic [OUT_WIDTH-1:0] scaled;

  function automatic logic [DLW-1:0] clamp_dlog2(input logic [DLW-1:0] d);
    logic [DLW-1:0] r;
    r = d;
    if (d == '0) r = DLW'(1);
    else if (int'(d) > MAX_DLOG2) r = DLW'(MAX_DLOG2);
    return r;
  endfunction

  // ratio is never below 1, so the phase-0 sample can never be the decimating one.
  assign last_phase = MAX_DLOG2'((32'd1 << ratio) - 32'd1);
  assign decimate   = in_valid && (phase == last_phase);

  // Integrators chain combinationally so the comb sees the decimating sample itself.
  always_comb begin
    reg_t acc;
    // NOTE: blocking '=' is intended here; acc is a combinational temporary carried down the chain.
    acc = {{(REG_WIDTH - IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
    for (int k = 0; k < STAGES; k++) begin
      acc           = integ[k] + acc;
      integ_next[k] = acc;
    end
    for (int j = 0; j < STAGES; j++) begin
      comb_tap[j] = acc;
      acc         = acc - dly[j];
    end
    comb_out = acc;
  end

  // Divide out the R^N gain (and any input/output width difference) with one variable shift.
  always_comb begin
    int         sh;
    wide_t      wide;
    logic [7:0] shamt;
    // NOTE: every variable gets a value before any branch so no latch can be inferred.
    scaled = '0;
    shamt  = '0;
    wide   = wide_t'($signed(comb_out));
    sh     = STAGES * int'(ratio) + IN_WIDTH - OUT_WIDTH;
    if (sh <= 0) begin
      shamt  = 8'(-sh);
      scaled = OUT_WIDTH'(comb_out << shamt);
    end else begin
      shamt = 8'(sh);
`ifdef CIC_ROUND_EN
      wide   = wide + (wide_t'(1) <<< (shamt - 8'd1));
      wide   = wide >>> shamt;
      scaled = (wide > OUT_MAX) ? OUT_MAX[OUT_WIDTH-1:0] : wide[OUT_WIDTH-1:0];
`else
      scaled = OUT_WIDTH'(wide >>> shamt);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: integ/dly are small register arrays, not RAM, so they take the async reset too.
      for (int k = 0; k < STAGES; k++) begin
        integ[k] <= '0;
        dly[k]   <= '0;
      end
      phase     <= '0;
      // The first accepted sample (phase 0) reloads ratio from dlog2 before it selects a period.
      ratio     <= DLW'(1);
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (in_valid) begin
        integ <= integ_next;
        phase <= decimate ? '0 : phase + MAX_DLOG2'(1);
        if (phase == '0) ratio <= clamp_dlog2(dlog2);
      end
      if (decimate) begin
        dly       <= comb_tap;
        out_data  <= scaled;
        out_valid <= 1'b1;
        overrun   <= out_valid & ~out_ready;
      end else begin
        overrun <= 1'b0;
        if (out_ready) out_valid <= 1'b0;
      end
    end
  end

endmodule
